dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the core LSU (cpu_*) and the debug/program-loader port (dbg_*).

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/arb_rr_pick.sv | 22 ++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter between the core LSU and the debug loader.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = DATA_W / 8;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CPU,
    WAIT_DBG
  } arb_state_e;

  typedef enum logic {
    REQ_CPU,
    REQ_DBG
  } req_id_e;

  // Command payload forwarded from the granted requester to the SRAM.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin winner selection; the requester that did not win last time gets a tie.
module arb_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic    req_cpu_i,
  input  logic    req_dbg_i,
  input  req_id_e rr_last_i,
  output logic    grant_valid_o,
  output req_id_e grant_id_o
);

  always_comb begin
    grant_valid_o = req_cpu_i | req_dbg_i;
    grant_id_o    = REQ_CPU;
    if (req_cpu_i && req_dbg_i) begin
      grant_id_o = (rr_last_i == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (req_dbg_i) begin
      grant_id_o = REQ_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-outstanding round-robin arbiter sharing the data SRAM between the LSU and the debug port.
// Optional WAIT timeout with error completion is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [BE_W-1:0]   cpu_be_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic [BE_W-1:0]   dbg_be_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [BE_W-1:0]   mem_be_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        state_q, state_d;
  req_id_e           rr_last_q, rr_last_d;
  req_id_e           pick_id;
  logic              pick_valid;
  logic              we_q, we_d;
  logic              expired;
  logic              cmp_err;
  logic [DATA_W-1:0] cmp_rdata;
  mem_cmd_t          cpu_cmd, dbg_cmd, win_cmd;

  assign cpu_cmd = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i, be: cpu_be_i};
  assign dbg_cmd = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i, be: dbg_be_i};
  assign win_cmd = (pick_id == REQ_CPU) ? cpu_cmd : dbg_cmd;

  arb_rr_pick u_pick (
    .req_cpu_i    (cpu_req_i),
    .req_dbg_i    (dbg_req_i),
    .rr_last_i    (rr_last_q),
    .grant_valid_o(pick_valid),
    .grant_id_o   (pick_id)
  );

`ifdef DMEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is held at zero in IDLE so every WAIT starts from a clean count.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!mem_rvalid_i) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        expired = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // A real memory response always beats a simultaneous timeout.
  assign cmp_err   = expired & ~mem_rvalid_i;
  assign cmp_rdata = (we_q || !mem_rvalid_i) ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_last_q <= REQ_DBG;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    we_d         = we_q;
    cpu_gnt_o    = 1'b0;
    dbg_gnt_o    = 1'b0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    cpu_err_o    = 1'b0;
    dbg_rvalid_o = 1'b0;
    dbg_rdata_o  = '0;
    dbg_err_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          mem_req_o   = 1'b1;
          mem_we_o    = win_cmd.we;
          mem_addr_o  = win_cmd.addr;
          mem_wdata_o = win_cmd.wdata;
          mem_be_o    = win_cmd.be;
          cpu_gnt_o   = (pick_id == REQ_CPU);
          dbg_gnt_o   = (pick_id == REQ_DBG);
          rr_last_d   = pick_id;
          we_d        = win_cmd.we;
          state_d     = (pick_id == REQ_CPU) ? WAIT_CPU : WAIT_DBG;
        end
      end
      WAIT_CPU, WAIT_DBG: begin
        if (mem_rvalid_i || expired) begin
          if (state_q == WAIT_CPU) begin
            cpu_rvalid_o = 1'b1;
            cpu_rdata_o  = cmp_rdata;
            cpu_err_o    = cmp_err;
          end else begin
            dbg_rvalid_o = 1'b1;
            dbg_rdata_o  = cmp_rdata;
            dbg_err_o    = cmp_err;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [13:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic [3:0]  cpu_be_i = '0;
  logic        cpu_gnt_o, cpu_rvalid_o, cpu_err_o;
  logic [31:0] cpu_rdata_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [13:0] dbg_addr_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic [3:0]  dbg_be_i = '0;
  logic        dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
  logic [31:0] dbg_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level reference: owner 0=none, 1=cpu, 2=dbg.
  int m_owner = 0;
  bit m_last_dbg = 1'b1;
  bit m_we = 1'b0;
  int m_wait = 0;
  bit g_cpu, g_dbg, done_c, done_err;

  // Memory responder state.
  int          mem_lat = 1;
  bit          mem_pending = 1'b0;
  int          mem_cd = 0;
  bit          no_resp = 1'b0;
  bit          inject = 1'b0;
  logic [31:0] rd_pat = '0;

  // Snapshots of DUT outputs from the last sampled cycle.
  logic        o_cgnt, o_dgnt, o_crv, o_drv, o_cerr, o_derr;
  logic [31:0] o_crd, o_drd, o_mwdata;
  logic [3:0]  o_mbe;
  logic        o_mwe;
  int          n_memreq = 0, n_cpu_rv = 0, n_dbg_rv = 0, n_cpu_gnt = 0, n_dbg_gnt = 0;
  int          q_gnt[$];
  int          q_gcyc[$];

  dmem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i), .cpu_gnt_o(cpu_gnt_o),
    .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_be_i(dbg_be_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, compare against the model, then advance model and memory.
  task automatic step();
    logic [63:0] e_mem, e_cc, e_dc;
    logic [31:0] rd;
    logic        saw_req;
    @(negedge clk_i);
    g_cpu = 1'b0; g_dbg = 1'b0; done_c = 1'b0; done_err = 1'b0;
    e_mem = '0; e_cc = '0; e_dc = '0;
    if (rst_ni) begin
      if (m_owner == 0) begin
        g_cpu = cpu_req_i && (!dbg_req_i || m_last_dbg);
        g_dbg = dbg_req_i && !g_cpu;
        if (g_cpu) e_mem = {12'b0, 1'b1, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i};
        if (g_dbg) e_mem = {12'b0, 1'b1, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i};
      end else begin
        if (mem_rvalid_i) done_c = 1'b1;
`ifdef DMEM_ARB_TIMEOUT_EN
        else if (m_wait == TO_CYC - 1) begin
          done_c = 1'b1;
          done_err = 1'b1;
        end
`endif
        rd = (done_err || m_we) ? 32'h0 : mem_rdata_i;
        if (done_c && m_owner == 1) e_cc = {30'b0, 1'b1, rd, done_err};
        if (done_c && m_owner == 2) e_dc = {30'b0, 1'b1, rd, done_err};
      end
    end
    chk("gnt", {62'b0, cpu_gnt_o, dbg_gnt_o}, {62'b0, g_cpu, g_dbg});
    chk("mem_bus", {12'b0, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, e_mem);
    chk("cpu_cpl", {30'b0, cpu_rvalid_o, cpu_rdata_o, cpu_err_o}, e_cc);
    chk("dbg_cpl", {30'b0, dbg_rvalid_o, dbg_rdata_o, dbg_err_o}, e_dc);
    o_cgnt = cpu_gnt_o; o_dgnt = dbg_gnt_o; o_crv = cpu_rvalid_o; o_drv = dbg_rvalid_o;
    o_cerr = cpu_err_o; o_derr = dbg_err_o; o_crd = cpu_rdata_o; o_drd = dbg_rdata_o;
    o_mwe = mem_we_o; o_mwdata = mem_wdata_o; o_mbe = mem_be_o;
    if (mem_req_o) n_memreq++;
    if (cpu_rvalid_o) n_cpu_rv++;
    if (dbg_rvalid_o) n_dbg_rv++;
    if (cpu_gnt_o) begin n_cpu_gnt++; q_gnt.push_back(1); q_gcyc.push_back(cyc); end
    if (dbg_gnt_o) begin n_dbg_gnt++; q_gnt.push_back(2); q_gcyc.push_back(cyc); end
    saw_req = mem_req_o;
    @(posedge clk_i);
    #1;
    cyc++;
    if (!rst_ni) begin
      m_owner = 0; m_last_dbg = 1'b1;
    end else if (g_cpu) begin
      m_owner = 1; m_last_dbg = 1'b0; m_we = cpu_we_i; m_wait = 0;
    end else if (g_dbg) begin
      m_owner = 2; m_last_dbg = 1'b1; m_we = dbg_we_i; m_wait = 0;
    end else if (m_owner != 0) begin
      if (done_c) m_owner = 0;
      else m_wait++;
    end
    mem_rvalid_i = 1'b0;
    if (saw_req) begin mem_pending = !no_resp; mem_cd = mem_lat; end
    if (mem_pending) begin
      if (mem_cd <= 1) begin mem_rvalid_i = 1'b1; mem_rdata_i = rd_pat; mem_pending = 1'b0; end
      else mem_cd--;
    end
    if (inject) begin mem_rvalid_i = 1'b1; mem_rdata_i = rd_pat; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_owner != 0 && k < 64) begin step(); k++; end
    chk("drain", 64'(m_owner == 0), 64'(1));
  endtask

  task automatic rand_cpu();
    cpu_we_i = 1'($urandom_range(0, 1)); cpu_addr_i = 14'($urandom);
    cpu_wdata_i = $urandom; cpu_be_i = 4'($urandom);
  endtask

  task automatic rand_dbg();
    dbg_we_i = 1'($urandom_range(0, 1)); dbg_addr_i = 14'($urandom);
    dbg_wdata_i = $urandom; dbg_be_i = 4'($urandom);
  endtask

  initial begin
    int nc, nd, w;
    #1 rst_ni = 1'b0;
    step(); step();
    chk("rst_gnt", {62'b0, o_cgnt, o_dgnt}, 64'(0));
    rst_ni = 1'b1;
    step();

    // CPU-only load with 1-cycle memory.
    mem_lat = 1; rd_pat = 32'hDEADBEEF; n_dbg_rv = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 14'h0010; cpu_be_i = 4'hF;
    step();
    chk("t1_gnt", 64'(o_cgnt), 64'(1));
    cpu_req_i = 1'b0;
    step();
    chk("t1_rvalid", 64'(o_crv), 64'(1));
    chk("t1_rdata", 64'(o_crd), 64'(32'hDEADBEEF));
    step();
    chk("t1_dbg_quiet", 64'(n_dbg_rv), 64'(0));

    // Contention from reset: strict alternation, one grant every two cycles.
    rst_ni = 1'b0; step(); rst_ni = 1'b1;
    q_gnt.delete(); q_gcyc.delete();
    nc = 0; nd = 0;
    rand_cpu(); rand_dbg(); cpu_req_i = 1'b1; dbg_req_i = 1'b1;
    for (int i = 0; i < 40 && (nc < 4 || nd < 4); i++) begin
      rd_pat = $urandom;
      step();
      if (o_cgnt) begin nc++; if (nc == 4) cpu_req_i = 1'b0; else rand_cpu(); end
      if (o_dgnt) begin nd++; if (nd == 4) dbg_req_i = 1'b0; else rand_dbg(); end
    end
    wait_idle();
    chk("t2_ngnt", 64'(q_gnt.size()), 64'(8));
    for (int i = 0; i < q_gnt.size() && i < 8; i++) begin
      chk("t2_order", 64'(q_gnt[i]), 64'((i % 2 == 0) ? 1 : 2));
      if (i > 0) chk("t2_spacing", 64'(q_gcyc[i] - q_gcyc[i-1]), 64'(2));
    end

    // DBG store while the CPU is held off.
    mem_lat = 3; n_cpu_gnt = 0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 14'h0200;
    dbg_wdata_i = 32'h12345678; dbg_be_i = 4'b0011;
    step();
    chk("t3_dbg_gnt", 64'(o_dgnt), 64'(1));
    chk("t3_mem_we", 64'(o_mwe), 64'(1));
    chk("t3_mem_wdata", 64'(o_mwdata), 64'(32'h12345678));
    chk("t3_mem_be", 64'(o_mbe), 64'(4'b0011));
    dbg_req_i = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 14'h0044;
    w = 0;
    do begin step(); w++; end while (!o_drv && w < 10);
    chk("t3_dbg_done", 64'(o_drv), 64'(1));
    chk("t3_dbg_rdata", 64'(o_drd), 64'(0));
    chk("t3_cpu_held", 64'(n_cpu_gnt), 64'(0));
    mem_lat = 1;
    step();
    chk("t3_cpu_after", 64'(o_cgnt), 64'(1));
    cpu_req_i = 1'b0;
    wait_idle();

    // 5-cycle memory latency.
    mem_lat = 5; n_memreq = 0; n_cpu_rv = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; rd_pat = 32'hA5A5_0F0F;
    step();
    cpu_req_i = 1'b0;
    w = 0;
    do begin step(); w++; end while (!o_crv && w < 20);
    step(); step(); step();
    chk("t4_memreq", 64'(n_memreq), 64'(1));
    chk("t4_wait", 64'(w), 64'(5));
    chk("t4_pulses", 64'(n_cpu_rv), 64'(1));

    // Reset during WAIT_CPU; the late memory response must be discarded.
    mem_lat = 6;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0;
    step();
    cpu_req_i = 1'b0;
    step();
    rst_ni = 1'b0; step(); step(); rst_ni = 1'b1;
    n_cpu_rv = 0; n_dbg_rv = 0;
    for (int i = 0; i < 6; i++) step();
    chk("t5_no_cpl", 64'(n_cpu_rv + n_dbg_rv), 64'(0));
    mem_lat = 1; cpu_req_i = 1'b1;
    step();
    chk("t5_regrant", 64'(o_cgnt), 64'(1));
    cpu_req_i = 1'b0;
    wait_idle();

    // Memory never responds.
    no_resp = 1'b1; cpu_req_i = 1'b1; cpu_we_i = 1'b0;
    step();
    cpu_req_i = 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
    w = 0;
    do begin step(); w++; end while (!o_crv && w < 24);
    chk("t6_expiry_cycle", 64'(w), 64'(16));
    chk("t6_err", 64'(o_cerr), 64'(1));
    chk("t6_rdata", 64'(o_crd), 64'(0));
    no_resp = 1'b0; n_cpu_rv = 0;
    inject = 1'b1; step(); inject = 1'b0; step(); step();
    chk("t6_late_ignored", 64'(n_cpu_rv), 64'(0));
`else
    n_cpu_rv = 0; n_dbg_gnt = 0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("t6_stuck_cpl", 64'(n_cpu_rv), 64'(0));
    chk("t6_stuck_gnt", 64'(n_dbg_gnt), 64'(0));
    no_resp = 1'b0;
    inject = 1'b1; step(); inject = 1'b0; step();
    chk("t6_release", 64'(o_crv), 64'(1));
    chk("t6_no_err", 64'(o_cerr), 64'(0));
    step();
    chk("t6_dbg_next", 64'(o_dgnt), 64'(1));
    dbg_req_i = 1'b0;
`endif
    wait_idle();

    // Random traffic, withdrawals and spurious responses.
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 4);
      rd_pat = $urandom;
      inject = ($urandom_range(0, 31) == 0) && !mem_pending;
      if (!cpu_req_i) begin
        if ($urandom_range(0, 2) == 0) begin rand_cpu(); cpu_req_i = 1'b1; end
      end else if ($urandom_range(0, 15) == 0) cpu_req_i = 1'b0;
      if (!dbg_req_i) begin
        if ($urandom_range(0, 2) == 0) begin rand_dbg(); dbg_req_i = 1'b1; end
      end else if ($urandom_range(0, 15) == 0) dbg_req_i = 1'b0;
      step();
      if (o_cgnt) begin cpu_req_i = 1'($urandom_range(0, 1)); rand_cpu(); end
      if (o_dgnt) begin dbg_req_i = 1'($urandom_range(0, 1)); rand_dbg(); end
    end
    inject = 1'b0; cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    wait_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
